// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS 5-stage pipeline slice.
// Holds default widths, control-bundle widths and the bit positions of
// each control signal inside the WB/M/EX bundles from the decoder.
package mips_pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // WB bundle {RegWrite, MemToReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    // M bundle {Branch, MemRead, MemWrite}
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    // EX bundle {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef logic [WB_W-1:0] wb_t;
    typedef logic [M_W-1:0]  m_t;
    typedef logic [EX_W-1:0] ex_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detector.
// Ports:
//   ex_valid, ex_memread, ex_rt : load currently in EX and its target
//   id_valid, id_rs, id_rt      : instruction currently in ID
//   flush                       : ID instruction is being squashed
//   stall                       : load-use stall required this cycle
// Both ID sources are compared regardless of opcode (conservative).
module hazard_detect import mips_pipe_pkg::*; #(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_valid,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  flush,
    output logic                  stall
);

    logic load_in_ex;
    logic src_match;

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign load_in_ex = ex_valid & ex_memread & (ex_rt != '0);
    assign src_match  = (ex_rt == id_rs) | (ex_rt == id_rt);
    // A flushed ID instruction is discarded anyway, so it must not hold the PC.
    assign stall      = load_in_ex & id_valid & src_match & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and branch flush.
// Ports:
//   clk, rst (async, active high)
//   id_*   : decoder control bundles, operands and specifiers from ID
//   flush  : squash the instruction in ID
//   ex_*   : registered copies presented to EX (ex_valid marks real instr)
//   pc_write, ifid_write : front-end enables, low while stalling
//   stall  : load-use stall active this cycle
// Optional: define IDEX_HAZARD_STATS_EN to add saturating stall_count and
// flush_count outputs.
module id_ex_stage import mips_pipe_pkg::*; #(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB_W-1:0]       id_wb,
    input  logic [M_W-1:0]        id_m,
    input  logic [EX_W-1:0]       id_ex,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc_plus4,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic [WB_W-1:0]       ex_wb,
    output logic [M_W-1:0]        ex_m,
    output logic [EX_W-1:0]       ex_ex,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc_plus4,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef IDEX_HAZARD_STATS_EN
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count,
`endif
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  stall
);

    logic bubble;

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .ex_valid   (ex_valid),
        .ex_memread (ex_m[M_MEMREAD]),
        .ex_rt      (ex_rt),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .flush      (flush),
        .stall      (stall)
    );

    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign bubble     = stall | flush | ~id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wb       <= '0;
            ex_m        <= '0;
            ex_ex       <= '0;
            ex_valid    <= 1'b0;
            ex_pc_plus4 <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else begin
            // Datapath fields are don't-care under a bubble; loading them
            // unconditionally keeps their enables off the critical path.
            ex_pc_plus4 <= id_pc_plus4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            if (bubble) begin
                ex_wb    <= '0;
                ex_m     <= '0;
                ex_ex    <= '0;
                ex_valid <= 1'b0;
            end else begin
                ex_wb    <= id_wb;
                ex_m     <= id_m;
                ex_ex    <= id_ex;
                ex_valid <= 1'b1;
            end
        end
    end

`ifdef IDEX_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
            if (flush && (flush_count != '1)) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations
// followed by random traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [3:0]  id_ex;
    logic        id_valid;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic [3:0]  ex_ex;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        pc_write, ifid_write, stall;
`ifdef IDEX_HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count;
`endif

    int vectors = 0;
    int errors  = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef IDEX_HAZARD_STATS_EN
        .stall_count(stall_count), .flush_count(flush_count),
`endif
        .pc_write(pc_write), .ifid_write(ifid_write), .stall(stall)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The instruction sitting in EX, as the spec describes it.
    logic        m_valid;
    logic [1:0]  m_wb;
    logic [2:0]  m_m;
    logic [3:0]  m_ex;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_scnt, m_fcnt;

    // A real load in EX writing a non-zero register that the real,
    // non-flushed ID instruction reads.
    function automatic logic model_stall();
        logic is_load, reads;
        is_load = m_valid && m_m[1] && (m_rt != 5'd0);
        reads   = (id_rs == m_rt) || (id_rt == m_rt);
        return is_load && id_valid && reads && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_wb = 0; m_m = 0; m_ex = 0;
            m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
            m_rs = 0; m_rt = 0; m_rd = 0;
            m_scnt = 0; m_fcnt = 0;
        end else begin
            logic st, keep;
            st   = model_stall();
            keep = id_valid && !flush && !st;
            if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            m_valid = keep;
            m_wb  = keep ? id_wb : 2'b00;
            m_m   = keep ? id_m  : 3'b000;
            m_ex  = keep ? id_ex : 4'b0000;
            m_pc = id_pc_plus4; m_a = id_rs_data; m_b = id_rt_data; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every negative edge, all outputs against the model.
    always @(negedge clk) begin
        logic es;
        es = model_stall();
        chk("m_ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("m_ex_wb",    32'(ex_wb),    32'(m_wb));
        chk("m_ex_m",     32'(ex_m),     32'(m_m));
        chk("m_ex_ex",    32'(ex_ex),    32'(m_ex));
        chk("m_ex_pc",    ex_pc_plus4,   m_pc);
        chk("m_ex_rsd",   ex_rs_data,    m_a);
        chk("m_ex_rtd",   ex_rt_data,    m_b);
        chk("m_ex_imm",   ex_imm,        m_imm);
        chk("m_ex_rs",    32'(ex_rs),    32'(m_rs));
        chk("m_ex_rt",    32'(ex_rt),    32'(m_rt));
        chk("m_ex_rd",    32'(ex_rd),    32'(m_rd));
        chk("m_stall",    32'(stall),    32'(es));
        chk("m_pc_write", 32'(pc_write), 32'(!es));
        chk("m_ifid",     32'(ifid_write), 32'(!es));
`ifdef IDEX_HAZARD_STATS_EN
        chk("m_scnt", stall_count, m_scnt);
        chk("m_fcnt", flush_count, m_fcnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_instr(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = 1; id_wb = wb; id_m = m; id_ex = ex;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    endtask

    initial begin
        rst = 1; flush = 0; id_valid = 0; id_wb = 0; id_m = 0; id_ex = 0;
        id_pc_plus4 = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        #12 rst = 0;

        // reset then idle
        step();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_wb",    32'(ex_wb),    32'd0);
        chk("rst_pcw",   32'(pc_write), 32'd1);
        chk("rst_stall", 32'(stall),    32'd0);

        // R-type
        set_instr(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3);
        step();
        chk("r_wb",    32'(ex_wb),    32'h2);
        chk("r_ex",    32'(ex_ex),    32'hC);
        chk("r_valid", 32'(ex_valid), 32'd1);
        chk("r_stall", 32'(stall),    32'd0);

        // lw $8 then add $9,$8,$10
        set_instr(2'b11, 3'b010, 4'b0001, 5'd4, 5'd8, 5'd0);
        step();
        chk("lw_m", 32'(ex_m), 32'h2);
        set_instr(2'b10, 3'b000, 4'b1100, 5'd8, 5'd10, 5'd9);
        #1;
        chk("lu_stall", 32'(stall),      32'd1);
        chk("lu_pcw",   32'(pc_write),   32'd0);
        chk("lu_ifid",  32'(ifid_write), 32'd0);
        step();
        chk("bub_valid", 32'(ex_valid), 32'd0);
        chk("bub_wb",    32'(ex_wb),    32'd0);
        chk("bub_stall", 32'(stall),    32'd0);
        step();
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_rs",    32'(ex_rs),    32'd8);
        chk("add_rd",    32'(ex_rd),    32'd9);

        // lw $0 then use of $0
        set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd0, 5'd0);
        step();
        set_instr(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd4);
        #1;
        chk("z_stall", 32'(stall), 32'd0);
        step();
        chk("z_valid", 32'(ex_valid), 32'd1);

        // flush together with load-use match
        set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd5, 5'd0);
        step();
        set_instr(2'b10, 3'b000, 4'b1100, 5'd5, 5'd2, 5'd6);
        flush = 1;
        #1;
        chk("f_stall", 32'(stall),    32'd0);
        chk("f_pcw",   32'(pc_write), 32'd1);
        step();
        flush = 0;
        chk("f_m",     32'(ex_m),     32'd0);
        chk("f_valid", 32'(ex_valid), 32'd0);

        // reset asserted mid-stall, between edges
        set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd6, 5'd0);
        step();
        set_instr(2'b10, 3'b000, 4'b1100, 5'd6, 5'd3, 5'd7);
        #1;
        chk("rs_stall_pre", 32'(stall), 32'd1);
        #1 rst = 1;
        #1;
        chk("rs_stall",  32'(stall),    32'd0);
        chk("rs_pcw",    32'(pc_write), 32'd1);
        chk("rs_valid",  32'(ex_valid), 32'd0);
        chk("rs_m",      32'(ex_m),     32'd0);
        step();
        rst = 0;

`ifdef IDEX_HAZARD_STATS_EN
        // three load-use pairs
        for (int k = 0; k < 3; k++) begin
            set_instr(2'b11, 3'b010, 4'b0001, 5'd1, 5'd9, 5'd0);
            step();
            set_instr(2'b10, 3'b000, 4'b1100, 5'd9, 5'd2, 5'd3);
            step();
            step();
        end
        chk("scnt3", stall_count, 32'd3);
`endif

        // random traffic; small register range makes hazards frequent
        for (int n = 0; n < 2000; n++) begin
            set_instr(2'($urandom), 3'($urandom), 4'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            id_valid = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) id_m[1] = 1'b1;
            step();
        end
        flush = 0; id_valid = 0;
        step();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
